// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned STEP_DEFAULT     = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port: request/address out, ready/data back in the same cycle.
interface fetch_if #(
    parameter int unsigned BUS = 32
);
    logic           imem_req;
    logic [BUS-1:0] imem_addr;
    logic           imem_ready;
    logic [BUS-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/pc_reg.sv
// Program counter: reset to RESET_PC, redirect load beats sequential increment (wraps modulo 2^BUS).
module pc_reg #(
    parameter int unsigned    BUS      = 32,
    parameter int unsigned    STEP     = 4,
    parameter logic [BUS-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_inc,
    input  logic           i_load,
    input  logic [BUS-1:0] i_load_addr,
    output logic [BUS-1:0] o_pc
);
    logic [BUS-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + BUS'(STEP);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// Fetch FSM + output register; one cycle from memory handshake to valid_out, stall freezes outputs in HOLD.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / redirect_count outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned    BUS      = 32,
    parameter int unsigned    STEP     = STEP_DEFAULT,
    parameter logic [BUS-1:0] RESET_PC = BUS'(RESET_PC_DEFAULT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           branch_taken,
    input  logic [BUS-1:0] jump_address,
    input  logic           stall,
    fetch_if.master        imem,
    output logic [BUS-1:0] inst_out,
    output logic [BUS-1:0] pc_out,
    output logic           valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]    fetch_count,
    output logic [31:0]    redirect_count
`endif
);
    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [BUS-1:0] w_pc;
    logic           w_out_ld;
    logic           w_valid_clr;
    logic           w_pc_inc;
    logic           w_pc_load;
    logic [BUS-1:0] r_inst;
    logic [BUS-1:0] r_pc_out;
    logic           r_valid;

    pc_reg #(
        .BUS      (BUS),
        .STEP     (STEP),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_pc_inc),
        .i_load      (w_pc_load),
        .i_load_addr (jump_address),
        .o_pc        (w_pc)
    );

    assign imem.imem_addr = w_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: redirect, then a held output under stall, then the memory handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_out_ld      = 1'b0;
        w_valid_clr   = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        imem.imem_req = (r_state != ST_HOLD);
        if (branch_taken) begin
            w_state_nxt = ST_FETCH;
            w_pc_load   = 1'b1;
            w_valid_clr = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (!stall) begin
                        w_state_nxt = ST_FETCH;
                        w_valid_clr = 1'b1;
                    end
                end
                ST_FETCH, ST_WAIT: begin
                    if (r_valid && stall) begin
                        w_state_nxt = ST_HOLD;
                    end else if (imem.imem_ready) begin
                        w_state_nxt = ST_FETCH;
                        w_out_ld    = 1'b1;
                        w_pc_inc    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_valid_clr = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_FETCH;
                    w_valid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst   <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (w_out_ld) begin
            r_inst   <= imem.imem_data;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
        end else if (w_valid_clr) begin
            r_valid  <= 1'b0;
        end
    end

    assign inst_out  = r_inst;
    assign pc_out    = r_pc_out;
    assign valid_out = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_out_ld && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (branch_taken && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign fetch_count    = r_fetch_cnt;
    assign redirect_count = r_redirect_cnt;
`endif
endmodule
